// File: rtl/exe_div_seq.sv
// rtl/exe_div_seq.sv - sequential restoring divider for EXE-stage DIV/DIVU/REM/REMU
module exe_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;      // dividend bits shift out of the top, quotient bits shift in
  logic [32:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;

  logic        is_signed, dvd_neg, dvs_neg;
  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] q_fix, r_fix;

  // Operand conditioning, one restoring step, and sign fix-up of the final values
  always_comb begin
    is_signed = ~op[0];
    dvd_neg   = is_signed & dividend[31];
    dvs_neg   = is_signed & divisor[31];
    // abs(0x80000000) wraps to 0x80000000, which is the right unsigned magnitude
    dvd_abs   = dvd_neg ? (32'd0 - dividend) : dividend;
    dvs_abs   = dvs_neg ? (32'd0 - divisor) : divisor;
    shifted   = {rem_q[31:0], quo_q[31]};
    diff      = {1'b0, shifted} - {2'b00, dvs_q};
    q_fix     = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    r_fix     = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  end

  // Next-state and datapath updates; flush kills the op from any state
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    if (flush) begin
      state_d = IDLE;
      count_d = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d      = op;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            dvs_d     = dvs_abs;
            quo_d     = dvd_abs;
            rem_d     = 33'd0;
            count_d   = 6'd0;
            if (divisor == 32'd0) begin
              result_d = op[1] ? dividend : 32'hFFFF_FFFF;
              state_d  = DONE;
            end else if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
              result_d = op[1] ? 32'd0 : 32'h8000_0000;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d   = diff[33] ? shifted : diff[32:0];
          quo_d   = {quo_q[30:0], ~diff[33]};
          count_d = count_q + 6'd1;
          if (count_q == 6'd31) state_d = FIX;
        end
        FIX: begin
          result_d = op_q[1] ? r_fix : q_fix;
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 6'd0;
      op_q      <= 2'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvs_q     <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 33'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  // Pipeline handshake: the DONE cycle releases the stall for the completing instruction
  always_comb begin
    stall  = start & ~flush & ~rst & (state_q != DONE);
    done   = (state_q == DONE);
    busy   = (state_q != IDLE);
    result = result_q;
  end

endmodule

// File: tb/tb_exe_div_seq.sv
// tb/tb_exe_div_seq.sv - directed table-driven bench for exe_div_seq
module tb_exe_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        stall, done, busy;
  logic [31:0] result;

  exe_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .stall(stall), .done(done),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  time done_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    bit          scr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns in the done cycle.
  task automatic run_op(input vec_t v);
    int lat = 0;
    int stalls = 0;
    bit got = 0;
    op = v.op; dividend = v.a; divisor = v.b; start = 1'b1; flush = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      lat++;
      if (done) begin
        got = 1;
        break;
      end
      if (stall) stalls++;
      if (v.scr && lat == 10) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
    end
    done_t = $time;
    chk({v.name, " done"}, 32'(got), 32'd1);
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.lat - 1));
    chk({v.name, " stall in done"}, {31'd0, stall}, 32'd0);
    chk({v.name, " result"}, result, v.exp);
  endtask

  task automatic watch_no_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t v;
    time  t1;
    vecs[0]  = '{"DIVU 100/7",      2'b01, 32'd100,        32'd7,          32'h0000_000E, 35, 1'b1};
    vecs[1]  = '{"REMU 100/7",      2'b11, 32'd100,        32'd7,          32'h0000_0002, 35, 1'b1};
    vecs[2]  = '{"DIV -7/2",        2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 35, 1'b0};
    vecs[3]  = '{"REM -7/2",        2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 35, 1'b0};
    vecs[4]  = '{"DIV 7/-2",        2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 35, 1'b0};
    vecs[5]  = '{"DIVU 5/0",        2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF, 2,  1'b0};
    vecs[6]  = '{"REMU 5/0",        2'b11, 32'd5,          32'd0,          32'h0000_0005, 2,  1'b0};
    vecs[7]  = '{"DIV ovf",         2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 2,  1'b0};
    vecs[8]  = '{"REM ovf",         2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 2,  1'b0};
    vecs[9]  = '{"DIVU max/1",      2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 35, 1'b0};
    vecs[10] = '{"REM min/3",       2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE, 35, 1'b0};
    vecs[11] = '{"DIV min/2",       2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000, 35, 1'b0};

    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk); #1;
    chk("stall under reset", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      run_op(vecs[k]);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({vecs[k].name, " idle after done"}, {31'd0, busy}, 32'd0);
      chk({vecs[k].name, " result held"}, result, vecs[k].exp);
      @(negedge clk);
    end

    // Flush in CALC with count=10
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush stall", {31'd0, stall}, 32'd0);
    chk("flush busy before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush idle", {31'd0, busy}, 32'd0);
    watch_no_done("flush no done");
    @(negedge clk);
    v = '{"DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 35, 1'b0};
    run_op(v);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // Back-to-back with start held through DONE
    v = '{"b2b DIVU 20/4", 2'b01, 32'd20, 32'd4, 32'd5, 35, 1'b0};
    run_op(v);
    t1 = done_t;
    @(negedge clk);
    v = '{"b2b REMU 20/6", 2'b11, 32'd20, 32'd6, 32'd2, 35, 1'b0};
    run_op(v);
    chk("b2b done spacing", 32'((done_t - t1) / 10), 32'd35);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // Reset during FIX
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (33) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst in FIX busy", {31'd0, busy}, 32'd1);
    chk("rst in FIX stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst in FIX idle", {31'd0, busy}, 32'd0);
    chk("rst in FIX result", result, 32'd0);
    chk("rst in FIX done", {31'd0, done}, 32'd0);
    watch_no_done("rst in FIX no done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
